motor_throttle_ramp: RTL and testbench



---
 rtl/motor_throttle_ramp.sv | 82 ++++++++
 tb/tb_motor_throttle_ramp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/motor_throttle_ramp.sv
// motor_throttle_ramp: slew-rate limited soft-start PWM command with brake; define RAMP_WATCHDOG_EN to enable the target watchdog
module motor_throttle_ramp #(
  parameter int STEP_DIV = 50000,
  parameter int STEP_UP = 4,
  parameter int STEP_DOWN = 16,
  parameter int MAX_CMD = 4095,
  parameter int WDOG_TICKS = 100
) (
  input  logic        PWMClock,
  input  logic        PWMReset,
  input  logic [11:0] TargetIn,
  input  logic        TargetValid,
  input  logic        Enable,
  input  logic        Brake,
  output logic [11:0] PWMout_cmd,
  output logic        AtTarget,
  output logic        Ramping,
  output logic        WatchdogTrip
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [12:0] UP = 13'(STEP_UP);
  localparam logic [12:0] DN = 13'(STEP_DOWN);
  localparam logic [11:0] MAXC = 12'(MAX_CMD);
  typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD, BRAKE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] tgt_q, tgt_d, out_q, out_d, eff, eff_d;
  logic [12:0] up_sum, dn_diff;
  logic tick, accept, at_q, at_d, trip_q, trip_d;
  assign tick = cnt_q == TICK_LAST;
  assign accept = TargetValid & ~Brake & ~trip_q;
  assign eff = Enable ? tgt_q : '0;
`ifdef RAMP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_TICKS);
  logic [WW-1:0] wd_q, wd_d;
  always_comb begin
    wd_d = accept ? '0 : (tick && wd_q != WD_LAST) ? wd_q + 1'b1 : wd_q;
    trip_d = trip_q | (wd_d == WD_LAST);
  end
  always_ff @(posedge PWMClock) begin
    wd_q <= PWMReset ? '0 : wd_d;
    trip_q <= PWMReset ? 1'b0 : trip_d;
  end
`else
  assign trip_q = 1'b0;
  assign trip_d = 1'b0;
`endif
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    up_sum = {1'b0, out_q} + UP;
    dn_diff = {1'b0, out_q} - DN;
    out_d = out_q;
    if (Brake) out_d = '0;
    else if (tick && eff > out_q) out_d = up_sum > {1'b0, eff} ? eff : up_sum[11:0];
    else if (tick && eff < out_q) out_d = (dn_diff[12] || dn_diff < {1'b0, eff}) ? eff : dn_diff[11:0];
    tgt_d = (Brake || trip_d) ? '0 : accept ? (TargetIn > MAXC ? MAXC : TargetIn) : tgt_q;
    eff_d = Enable ? tgt_d : '0;
    at_d = out_d == eff_d;
    state_d = Brake ? BRAKE : eff_d > out_d ? RAMP_UP : eff_d < out_d ? RAMP_DOWN : eff_d != '0 ? HOLD : IDLE;
  end
  always_ff @(posedge PWMClock) begin
    if (PWMReset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tgt_q <= '0;
      out_q <= '0;
      at_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      out_q <= out_d;
      at_q <= at_d;
    end
  end
  assign PWMout_cmd = out_q;
  assign AtTarget = at_q;
  assign Ramping = state_q == RAMP_UP || state_q == RAMP_DOWN;
  assign WatchdogTrip = trip_q & (WDOG_TICKS > 0);
endmodule

// File: tb/tb_motor_throttle_ramp.sv
// tb_motor_throttle_ramp: randomized and directed checks of motor_throttle_ramp against a behavioural model
module tb_motor_throttle_ramp;
  localparam int SD = 4, SU = 4, SDN = 16, MX = 100, WD = 1000;
  logic clk = 1'b0, rst = 1'b1, tv = 1'b0, en = 1'b0, brk = 1'b0;
  logic [11:0] ti = '0;
  logic [11:0] cmd, w_cmd;
  logic at, rmp, wt, w_at, w_rmp, w_wt;
  int checks = 0, errors = 0;
  int m_out, m_tgt, m_cnt, m_wd;
  bit m_trip, m_at, m_rmp;
  int chg[$];
  motor_throttle_ramp #(.STEP_DIV(SD), .STEP_UP(SU), .STEP_DOWN(SDN), .MAX_CMD(MX), .WDOG_TICKS(WD)) dut (
    .PWMClock(clk), .PWMReset(rst), .TargetIn(ti), .TargetValid(tv), .Enable(en), .Brake(brk),
    .PWMout_cmd(cmd), .AtTarget(at), .Ramping(rmp), .WatchdogTrip(wt));
  motor_throttle_ramp #(.STEP_DIV(SD), .STEP_UP(SU), .STEP_DOWN(SDN), .MAX_CMD(MX), .WDOG_TICKS(3)) dut_wd (
    .PWMClock(clk), .PWMReset(rst), .TargetIn(ti), .TargetValid(tv), .Enable(en), .Brake(brk),
    .PWMout_cmd(w_cmd), .AtTarget(w_at), .Ramping(w_rmp), .WatchdogTrip(w_wt));
  always #5 clk = ~clk;
  task automatic step();
    bit tk;
    int eff;
    tk = m_cnt == SD - 1;
    if (rst) begin
      m_out = 0; m_tgt = 0; m_cnt = 0; m_wd = 0; m_trip = 0;
    end else begin
      eff = en ? m_tgt : 0;
      if (brk) begin
        m_out = 0; m_tgt = 0;
      end else begin
        if (tk && eff > m_out) m_out = (m_out + SU > eff) ? eff : m_out + SU;
        else if (tk && eff < m_out) m_out = (m_out - SDN < eff) ? eff : m_out - SDN;
        if (tv && !m_trip) m_tgt = (int'(ti) > MX) ? MX : int'(ti);
      end
`ifdef RAMP_WATCHDOG_EN
      if (tv && !brk && !m_trip) m_wd = 0;
      else if (tk && m_wd < WD) m_wd++;
      if (m_wd >= WD) begin m_trip = 1; m_tgt = 0; end
`endif
      m_cnt = (m_cnt + 1) % SD;
    end
    m_at = m_out == (en ? m_tgt : 0);
    m_rmp = !m_at;
    @(posedge clk);
    #1;
  endtask
  task automatic collect(input int n, input bit use_wd);
    logic [11:0] p;
    chg.delete();
    for (int i = 0; i < n; i++) begin
      p = use_wd ? w_cmd : cmd;
      step();
      if ((use_wd ? w_cmd : cmd) !== p) chg.push_back(int'(use_wd ? w_cmd : cmd));
    end
  endtask
  function automatic bit same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction
  task automatic strobe(input int v);
    ti = 12'(v); tv = 1'b1; step(); tv = 1'b0;
  endtask
  task automatic settle(input int v);
    for (int i = 0; i < 400 && cmd !== 12'(v); i++) step();
  endtask
  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (cmd !== 12'd0 || at !== 1'b1 || rmp !== 1'b0 || wt !== 1'b0 || w_wt !== 1'b0) begin
      errors++; $display("FAIL reset cmd=%0d at=%b rmp=%b wt=%b wwt=%b want 0 1 0 0 0", cmd, at, rmp, wt, w_wt);
    end
  endtask
  task automatic test_ramp_up();
    int e[$] = '{4, 8, 10};
    en = 1'b1; strobe(10);
    checks++;
    if (rmp !== 1'b1) begin errors++; $display("FAIL rampup_start rmp=%b want 1", rmp); end
    collect(20, 0);
    checks++;
    if (!same(chg, e)) begin errors++; $display("FAIL rampup_seq got %p want %p", chg, e); end
    checks++;
    if (at !== 1'b1 || rmp !== 1'b0) begin errors++; $display("FAIL rampup_end at=%b rmp=%b want 1 0", at, rmp); end
  endtask
  task automatic test_ramp_down();
    int e[$] = '{24, 8, 5};
    strobe(40); settle(40);
    checks++;
    if (cmd !== 12'd40) begin errors++; $display("FAIL rampdown_hold40 cmd=%0d want 40", cmd); end
    strobe(5); collect(20, 0);
    checks++;
    if (!same(chg, e)) begin errors++; $display("FAIL rampdown_seq got %p want %p", chg, e); end
    checks++;
    if (at !== 1'b1 || rmp !== 1'b0 || cmd !== 12'd5) begin errors++; $display("FAIL rampdown_hold cmd=%0d at=%b rmp=%b want 5 1 0", cmd, at, rmp); end
  endtask
  task automatic test_clamp();
    int e[$] = '{0};
    strobe(4095); settle(MX); collect(12, 0);
    checks++;
    if (cmd !== 12'(MX) || at !== 1'b1 || chg.size() != 0) begin errors++; $display("FAIL clamp cmd=%0d at=%b want %0d 1", cmd, at, MX); end
    strobe(8); settle(8);
    checks++;
    if (cmd !== 12'd8) begin errors++; $display("FAIL clamp_down8 cmd=%0d want 8", cmd); end
    strobe(0); collect(16, 0);
    checks++;
    if (!same(chg, e) || at !== 1'b1 || rmp !== 1'b0) begin errors++; $display("FAIL underflow got %p at=%b want '{0} at=1", chg, at); end
  endtask
  task automatic test_brake();
    strobe(40); settle(20);
    checks++;
    if (cmd !== 12'd20) begin errors++; $display("FAIL brake_pre cmd=%0d want 20", cmd); end
    brk = 1'b1; step();
    checks++;
    if (cmd !== 12'd0 || rmp !== 1'b0) begin errors++; $display("FAIL brake_latency cmd=%0d rmp=%b want 0 0", cmd, rmp); end
    brk = 1'b0; collect(20, 0);
    checks++;
    if (cmd !== 12'd0 || chg.size() != 0) begin errors++; $display("FAIL brake_release cmd=%0d changes=%0d want 0 0", cmd, chg.size()); end
    brk = 1'b1; strobe(50); brk = 1'b0; collect(20, 0);
    checks++;
    if (cmd !== 12'd0 || at !== 1'b1 || chg.size() != 0) begin errors++; $display("FAIL brake_vs_valid cmd=%0d at=%b want 0 1", cmd, at); end
  endtask
  task automatic test_enable_reset();
    int e[$] = '{24, 8, 0};
    strobe(40); settle(40);
    en = 1'b0; collect(20, 0);
    checks++;
    if (!same(chg, e) || at !== 1'b1 || rmp !== 1'b0) begin errors++; $display("FAIL enable_drop got %p at=%b rmp=%b want %p 1 0", chg, at, rmp, e); end
    en = 1'b1; collect(10, 0);
    checks++;
    if (cmd === 12'd0 || rmp !== 1'b1) begin errors++; $display("FAIL enable_resume cmd=%0d rmp=%b want >0 1", cmd, rmp); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (cmd !== 12'd0 || at !== 1'b1 || rmp !== 1'b0 || wt !== 1'b0) begin errors++; $display("FAIL reset_midramp cmd=%0d at=%b rmp=%b wt=%b want 0 1 0 0", cmd, at, rmp, wt); end
    collect(12, 0);
    checks++;
    if (cmd !== 12'd0) begin errors++; $display("FAIL reset_residual cmd=%0d want 0", cmd); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 199) == 0;
      tv = $urandom_range(0, 9) == 0;
      ti = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 120));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) brk = ~brk;
      step();
      checks++;
      if (cmd !== 12'(m_out) || at !== m_at || rmp !== m_rmp || wt !== m_trip) begin
        errors++;
        $display("FAIL random[%0d] cmd=%0d/%0d at=%b/%b rmp=%b/%b wt=%b/%b", i, cmd, m_out, at, m_at, rmp, m_rmp, wt, m_trip);
      end
    end
    rst = 1'b0; tv = 1'b0; brk = 1'b0; en = 1'b1;
  endtask
`ifdef RAMP_WATCHDOG_EN
  task automatic test_watchdog();
    int e[$] = '{4, 8, 12, 0};
    bit trip_at_12 = 0;
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    strobe(12);
    chg.delete();
    for (int i = 0; i < 40; i++) begin
      step();
      if (w_cmd === 12'd12 && w_wt === 1'b1 && chg.size() == 2) trip_at_12 = 1;
      if (chg.size() == 0 ? w_cmd !== 12'd0 : w_cmd !== 12'(chg[chg.size()-1])) chg.push_back(int'(w_cmd));
    end
    checks++;
    if (!same(chg, e) || !trip_at_12 || w_wt !== 1'b1) begin errors++; $display("FAIL watchdog_trip got %p trip12=%b wt=%b want %p 1 1", chg, trip_at_12, w_wt, e); end
    strobe(50); collect(20, 1);
    checks++;
    if (w_cmd !== 12'd0 || chg.size() != 0 || w_wt !== 1'b1) begin errors++; $display("FAIL watchdog_ignore cmd=%0d wt=%b want 0 1", w_cmd, w_wt); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (w_wt !== 1'b0 || w_cmd !== 12'd0) begin errors++; $display("FAIL watchdog_reset wt=%b cmd=%0d want 0 0", w_wt, w_cmd); end
  endtask
`endif
  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_brake();
    test_enable_reset();
    test_random();
`ifdef RAMP_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
